// File: rtl/dallanma_ongoru_birimi.sv
// Branch resolution unit with a direct-mapped BTB and 2-bit saturating predictor.
// The fetch side gets a registered taken/target prediction. The execute side
// resolves control micro-ops combinationally, then trains the table and the counters.
module dallanma_ongoru_birimi #(
  parameter int XLEN         = 32,
  parameter int GIRDI_SAYISI = 16
) (
  input  logic            clk_g,
  input  logic            rst_g,
  input  logic            ongoru_gecerli_g,
  input  logic [XLEN-1:0] ongoru_ps_g,
  output logic            ongoru_gecerli_c,
  output logic            ongoru_atla_c,
  output logic [XLEN-1:0] ongoru_hedef_c,
  input  logic            cozum_gecerli_g,
  input  logic [7:0]      islev_kodu_g,
  input  logic [XLEN-1:0] ps_g,
  input  logic [XLEN-1:0] islec1_g,
  input  logic [XLEN-1:0] islec2_g,
  input  logic [XLEN-1:0] anlik_g,
  input  logic            tahmin_atla_g,
  input  logic [XLEN-1:0] tahmin_hedef_g,
  output logic [XLEN-1:0] jal_sonuc_c,
  output logic            dallanma_sonuc_c,
  output logic [XLEN-1:0] ps_c,
  output logic            yanlis_tahmin_c,
  output logic [XLEN-1:0] duzeltme_ps_c,
  output logic [31:0]     dallanma_sayisi_c,
  output logic [31:0]     yanlis_sayisi_c
);

  localparam int IDX = $clog2(GIRDI_SAYISI);
  localparam int TAG = XLEN - 2 - IDX;

  // Micro-op codes shared with the decoder.
  localparam logic [7:0] OP_JAL  = 8'h30;
  localparam logic [7:0] OP_JALR = 8'h31;
  localparam logic [7:0] OP_BEQ  = 8'h32;
  localparam logic [7:0] OP_BNE  = 8'h33;
  localparam logic [7:0] OP_BLT  = 8'h34;
  localparam logic [7:0] OP_BGE  = 8'h35;
  localparam logic [7:0] OP_BLTU = 8'h36;
  localparam logic [7:0] OP_BGEU = 8'h37;

  // Table storage; the reset clears every entry, so it lives in flops.
  logic            valid_reg   [GIRDI_SAYISI];
  logic [TAG-1:0]  tag_reg     [GIRDI_SAYISI];
  logic [XLEN-1:0] target_reg  [GIRDI_SAYISI];
  logic [1:0]      ctr_reg     [GIRDI_SAYISI];
  logic            sicrama_reg [GIRDI_SAYISI];

  logic            is_ctrl, is_jump, taken;
  logic [XLEN-1:0] target, ps_arti4;

  assign ps_arti4 = ps_g + XLEN'(4);

  // Decode the op, evaluate the branch condition and compute the target.
  always_comb begin
    is_ctrl = 1'b0;
    is_jump = 1'b0;
    taken   = 1'b0;
    target  = '0;
    if (cozum_gecerli_g) begin
      case (islev_kodu_g)
        OP_JAL:  begin is_ctrl = 1'b1; is_jump = 1'b1; taken = 1'b1; target = ps_g + islec2_g; end
        OP_JALR: begin
          is_ctrl = 1'b1; is_jump = 1'b1; taken = 1'b1;
          target  = (islec1_g + islec2_g) & {{(XLEN-1){1'b1}}, 1'b0};
        end
        OP_BEQ:  begin is_ctrl = 1'b1; taken = (islec1_g == islec2_g); target = ps_g + anlik_g; end
        OP_BNE:  begin is_ctrl = 1'b1; taken = (islec1_g != islec2_g); target = ps_g + anlik_g; end
        OP_BLT:  begin is_ctrl = 1'b1; taken = ($signed(islec1_g) <  $signed(islec2_g)); target = ps_g + anlik_g; end
        OP_BGE:  begin is_ctrl = 1'b1; taken = ($signed(islec1_g) >= $signed(islec2_g)); target = ps_g + anlik_g; end
        OP_BLTU: begin is_ctrl = 1'b1; taken = (islec1_g <  islec2_g); target = ps_g + anlik_g; end
        OP_BGEU: begin is_ctrl = 1'b1; taken = (islec1_g >= islec2_g); target = ps_g + anlik_g; end
        default: ;
      endcase
    end
  end

  assign dallanma_sonuc_c = taken;
  assign ps_c             = target;
  assign jal_sonuc_c      = is_jump ? ps_arti4 : '0;
  assign yanlis_tahmin_c  = is_ctrl && ((taken != tahmin_atla_g) || (taken && (target != tahmin_hedef_g)));
  assign duzeltme_ps_c    = !is_ctrl ? '0 : (taken ? target : ps_arti4);

  // Fetch-side lookup and execute-side update addressing.
  logic [IDX-1:0] lk_idx, up_idx;
  logic [TAG-1:0] lk_tag, up_tag;
  logic           lk_atla, up_hit;

  assign lk_idx  = ongoru_ps_g[IDX+1:2];
  assign lk_tag  = ongoru_ps_g[XLEN-1:IDX+2];
  assign up_idx  = ps_g[IDX+1:2];
  assign up_tag  = ps_g[XLEN-1:IDX+2];
  assign lk_atla = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag) &&
                   (sicrama_reg[lk_idx] || ctr_reg[lk_idx][1]);
  assign up_hit  = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);

  // Train the table on every control op: hits move the counter, taken misses allocate.
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      for (int i = 0; i < GIRDI_SAYISI; i++) begin
        valid_reg[i]   <= 1'b0;
        tag_reg[i]     <= '0;
        target_reg[i]  <= '0;
        ctr_reg[i]     <= 2'b00;
        sicrama_reg[i] <= 1'b0;
      end
    end else if (is_ctrl) begin
      if (up_hit) begin
        if (taken) begin
          ctr_reg[up_idx]    <= (ctr_reg[up_idx] == 2'b11) ? 2'b11 : ctr_reg[up_idx] + 2'd1;
          target_reg[up_idx] <= target;
        end else begin
          ctr_reg[up_idx]    <= (ctr_reg[up_idx] == 2'b00) ? 2'b00 : ctr_reg[up_idx] - 2'd1;
        end
        sicrama_reg[up_idx] <= is_jump;
      end else if (taken) begin
        valid_reg[up_idx]   <= 1'b1;
        tag_reg[up_idx]     <= up_tag;
        target_reg[up_idx]  <= target;
        ctr_reg[up_idx]     <= 2'b10;
        sicrama_reg[up_idx] <= is_jump;
      end
    end
  end

  // Register the prediction; nonblocking reads give the pre-update entry contents.
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      ongoru_gecerli_c <= 1'b0;
      ongoru_atla_c    <= 1'b0;
      ongoru_hedef_c   <= '0;
    end else begin
      ongoru_gecerli_c <= ongoru_gecerli_g;
      if (ongoru_gecerli_g) begin
        ongoru_atla_c  <= lk_atla;
        ongoru_hedef_c <= lk_atla ? target_reg[lk_idx] : ongoru_ps_g + XLEN'(4);
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      dallanma_sayisi_c <= '0;
      yanlis_sayisi_c   <= '0;
    end else begin
      if (is_ctrl && (dallanma_sayisi_c != 32'hFFFF_FFFF))
        dallanma_sayisi_c <= dallanma_sayisi_c + 32'd1;
      if (yanlis_tahmin_c && (yanlis_sayisi_c != 32'hFFFF_FFFF))
        yanlis_sayisi_c <= yanlis_sayisi_c + 32'd1;
    end
  end

endmodule
